// File: rtl/genx_qspi_slave_if.sv
// genx_qspi_slave_if: QSPI pins plus handler-facing capture/readback signals
interface genx_qspi_slave_if;
    logic         sck;
    logic [1:0]   cs_n;
    logic [3:0]   dq_h_in;
    logic [3:0]   dq_l_in;
    logic [3:0]   dq_h_out;
    logic [3:0]   dq_l_out;
    logic         dq_oe;
    logic [9:0]   sck_counts;
    logic [7:0]   opcode;
    logic [31:0]  address;
    logic [1:0]   chip_select;
    logic [255:0] wdata_h;
    logic [255:0] wdata_l;
    logic [255:0] rdata_h;
    logic [255:0] rdata_l;
    logic         notify_read;
    logic         notify_write;
    modport slave (
        input  sck, cs_n, dq_h_in, dq_l_in, rdata_h, rdata_l,
        output dq_h_out, dq_l_out, dq_oe, sck_counts, opcode, address,
               chip_select, wdata_h, wdata_l, notify_read, notify_write
    );
    modport master (
        output sck, cs_n, dq_h_in, dq_l_in, rdata_h, rdata_l,
        input  dq_h_out, dq_l_out, dq_oe, sck_counts, opcode, address,
               chip_select, wdata_h, wdata_l, notify_read, notify_write
    );
endinterface

// File: rtl/genx_qspi_slave.sv
// genx_qspi_slave: oversampled QSPI target that captures command/write data and serializes read data
module genx_qspi_slave #(
    parameter int SYNC_STAGES   = 2,
    parameter int DUMMY_CLKS    = 4,
    parameter int RD_OPCODE_BIT = 7
) (
    input  logic clk,
    input  logic resetn,
    genx_qspi_slave_if.slave bus
);
    localparam int W = 11;
    typedef enum logic [2:0] {IDLE, CMD, DUMMY, DATA_WR, DATA_RD} state_t;
    state_t                 state;
    logic [SYNC_STAGES*W-1:0] sync;
    logic                   sck_s, sck_d, rise, fall, start, stop, loaded;
    logic [1:0]             cs_s, cs_d;
    logic [3:0]             dqh_s, dql_s;
    logic [9:0]             wk;
    logic [255:0]           sr_h, sr_l;
    assign {sck_s, cs_s, dqh_s, dql_s} = sync[SYNC_STAGES*W-1 -: W];
    assign rise  = sck_s & ~sck_d;
    assign fall  = ~sck_s & sck_d;
    assign start = state == IDLE && cs_d == 2'b11 && cs_s != 2'b11;
    assign stop  = state != IDLE && cs_s == 2'b11;
    // write nibble index: edge 11 lands in bits [255:252]
    assign wk    = bus.sck_counts - 10'd10;
    // input synchronizers plus delayed copies for edge detection
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync  <= '0;
            sck_d <= 1'b0;
            cs_d  <= 2'b00;
        end else begin
            sync  <= {sync[(SYNC_STAGES-1)*W-1:0], bus.sck, bus.cs_n, bus.dq_h_in, bus.dq_l_in};
            sck_d <= sck_s;
            cs_d  <= cs_s;
        end
    end
    // read nibbles are registered one cycle after the shift register moves
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.dq_h_out <= 4'h0;
            bus.dq_l_out <= 4'h0;
        end else begin
            bus.dq_h_out <= sr_h[255:252];
            bus.dq_l_out <= sr_l[255:252];
        end
    end
    // transaction state machine; deassertion outranks any same-cycle SCK edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state            <= IDLE;
            bus.sck_counts   <= '0;
            bus.opcode       <= '0;
            bus.address      <= '0;
            bus.chip_select  <= '0;
            bus.wdata_h      <= '0;
            bus.wdata_l      <= '0;
            bus.notify_read  <= 1'b0;
            bus.notify_write <= 1'b0;
            bus.dq_oe        <= 1'b0;
            sr_h             <= '0;
            sr_l             <= '0;
            loaded           <= 1'b0;
        end else if (start) begin
            state            <= CMD;
            bus.sck_counts   <= '0;
            bus.opcode       <= '0;
            bus.address      <= '0;
            bus.wdata_h      <= '0;
            bus.wdata_l      <= '0;
            bus.notify_read  <= 1'b0;
            bus.notify_write <= 1'b0;
            sr_h             <= '0;
            sr_l             <= '0;
            loaded           <= 1'b0;
        end else if (stop) begin
            state            <= IDLE;
            bus.dq_oe        <= 1'b0;
            bus.notify_write <= bus.sck_counts >= 10'd10;
        end else if (state != IDLE) begin
            if (state != CMD)
                bus.notify_read <= 1'b1;
            if (rise) begin
                if (bus.sck_counts != 10'h3ff)
                    bus.sck_counts <= bus.sck_counts + 10'd1;
                case (state)
                    CMD: begin
                        if (bus.sck_counts == 10'd0)
                            bus.chip_select <= ~cs_s;
                        if (bus.sck_counts < 10'd2)
                            bus.opcode <= {bus.opcode[3:0], dqh_s};
                        else
                            bus.address <= {bus.address[27:0], dqh_s};
                        if (bus.sck_counts == 10'd9)
                            state <= bus.opcode[RD_OPCODE_BIT] ? DUMMY : DATA_WR;
                    end
                    DUMMY: if (bus.sck_counts == 10'(9 + DUMMY_CLKS)) state <= DATA_RD;
                    DATA_WR: if (wk < 10'd64) begin
                        bus.wdata_h[{~wk[5:0], 2'b00} +: 4] <= dqh_s;
                        bus.wdata_l[{~wk[5:0], 2'b00} +: 4] <= dql_s;
                    end
                    default: ;
                endcase
            end
            if (fall && state == DATA_RD) begin
                sr_h      <= loaded ? {sr_h[251:0], 4'h0} : bus.rdata_h;
                sr_l      <= loaded ? {sr_l[251:0], 4'h0} : bus.rdata_l;
                loaded    <= 1'b1;
                bus.dq_oe <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_genx_qspi_slave.sv
// tb_genx_qspi_slave: directed QSPI transactions checked by a queue-based scoreboard
module tb_genx_qspi_slave;
    localparam int SS = 2;
    localparam int HP = 50;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    genx_qspi_slave_if bus();
    genx_qspi_slave #(.SYNC_STAGES(SS), .DUMMY_CLKS(4), .RD_OPCODE_BIT(7)) dut (
        .clk(clk), .resetn(resetn), .bus(bus)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [7:0]   op;
        logic [31:0]  addr;
        logic [1:0]   cs;
        logic [9:0]   cnt;
        logic         nr, nw;
        logic [255:0] wh, wl;
    } rec_t;
    typedef struct {
        logic [3:0] h, l;
    } nib_t;
    rec_t exp_q[$];
    nib_t nib_q[$];
    int   checks = 0;
    int   errors = 0;
    int   edges_sent = 0;
    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask
    task automatic push_rec(input logic [7:0] op, input logic [31:0] addr, input logic [1:0] cs,
                            input logic [9:0] cnt, input logic nr, input logic nw,
                            input logic [255:0] wh, input logic [255:0] wl);
        rec_t r;
        r.op = op; r.addr = addr; r.cs = cs; r.cnt = cnt; r.nr = nr; r.nw = nw; r.wh = wh; r.wl = wl;
        exp_q.push_back(r);
    endtask
    task automatic pulse(input logic [3:0] h, input logic [3:0] l);
        bus.dq_h_in = h;
        bus.dq_l_in = l;
        #HP bus.sck = 1'b1;
        edges_sent++;
        #HP bus.sck = 1'b0;
    endtask
    task automatic cmd(input logic [1:0] cs, input logic [7:0] op, input logic [31:0] addr, input int n);
        logic [39:0] c;
        c = {op, addr};
        edges_sent = 0;
        bus.cs_n = cs;
        #HP;
        for (int i = 0; i < n; i++) pulse(c[39-4*i -: 4], 4'h0);
    endtask
    task automatic endt();
        bus.cs_n = 2'b11;
        #(2*HP);
    endtask
    // end-of-transaction monitor: compares captured fields once deassertion has propagated
    initial begin
        logic [1:0] cs_prev;
        int         cd;
        bit         seen_rel;
        rec_t       r;
        cs_prev = 2'b11; cd = 0; seen_rel = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!seen_rel && resetn) begin
                seen_rel = 1;
                cd = 1;
            end else if (cs_prev != 2'b11 && bus.cs_n == 2'b11) begin
                cd = SS + 1;
            end else if (cd > 1) begin
                cd--;
            end else if (cd == 1) begin
                cd = 0;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rec_empty: got no expected record want one");
                end else begin
                    r = exp_q.pop_front();
                    chk("opcode", bus.opcode, r.op);
                    chk("address", bus.address, r.addr);
                    chk("chip_select", bus.chip_select, r.cs);
                    chk("sck_counts", bus.sck_counts, r.cnt);
                    chk("notify_read", bus.notify_read, r.nr);
                    chk("notify_write", bus.notify_write, r.nw);
                    chk("dq_oe", bus.dq_oe, 1'b0);
                    chk("wdata_h", bus.wdata_h, r.wh);
                    chk("wdata_l", bus.wdata_l, r.wl);
                end
            end
            cs_prev = bus.cs_n;
        end
    end
    // host-side sampling of read nibbles on each SCK rise while driven
    always @(posedge bus.sck) begin
        if (bus.dq_oe) begin
            if (nib_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL nib_extra: got %h/%h want none", bus.dq_h_out, bus.dq_l_out);
            end else begin
                nib_t n;
                n = nib_q.pop_front();
                chk("dq_h_out", bus.dq_h_out, n.h);
                chk("dq_l_out", bus.dq_l_out, n.l);
            end
        end
    end
    // notify_read must rise between the 10th and 11th SCK rise
    always @(posedge bus.notify_read) chk("nr_edge", edges_sent, 10);
    initial begin
        logic [31:0] rh, rl;
        bus.sck = 1'b0; bus.cs_n = 2'b11; bus.dq_h_in = 4'h0; bus.dq_l_in = 4'h0;
        bus.rdata_h = '0; bus.rdata_l = '0;
        push_rec(8'h00, 32'h0, 2'b00, 10'd0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        #(2*HP);
        // reset asserted mid-write aborts without notify
        push_rec(8'h00, 32'h0, 2'b00, 10'd0, 1'b0, 1'b0, '0, '0);
        cmd(2'b01, 8'h02, 32'h0000_1234, 10);
        pulse(4'h7, 4'h7);
        pulse(4'h7, 4'h7);
        resetn = 1'b0;
        #20 bus.cs_n = 2'b11;
        #10 resetn = 1'b1;
        #(2*HP);
        // host write
        push_rec(8'h02, 32'h0000_1234, 2'b10, 10'd18, 1'b1, 1'b1,
                 {32'hDEADBEEF, 224'h0}, {32'h12345678, 224'h0});
        cmd(2'b01, 8'h02, 32'h0000_1234, 10);
        rh = 32'hDEADBEEF;
        rl = 32'h12345678;
        for (int i = 0; i < 8; i++) pulse(rh[31-4*i -: 4], rl[31-4*i -: 4]);
        endt();
        // bank read with 4 dummy clocks
        bus.rdata_h = {32'hCAFEF00D, 224'h0};
        bus.rdata_l = {32'h13579BDF, 224'h0};
        rh = 32'hCAFEF00D;
        rl = 32'h13579BDF;
        for (int i = 0; i < 8; i++) begin
            nib_t n;
            n.h = rh[31-4*i -: 4];
            n.l = rl[31-4*i -: 4];
            nib_q.push_back(n);
        end
        push_rec(8'h83, 32'hA5A5_0001, 2'b01, 10'd22, 1'b1, 1'b1, '0, '0);
        cmd(2'b10, 8'h83, 32'hA5A5_0001, 10);
        for (int i = 0; i < 12; i++) pulse(4'h0, 4'h0);
        endt();
        // runt
        push_rec(8'h12, 32'h0000_3456, 2'b11, 10'd6, 1'b0, 1'b0, '0, '0);
        cmd(2'b00, 8'h12, 32'h3456_0000, 6);
        endt();
        // overrun: edges past 74 drive F and must be discarded
        push_rec(8'h01, 32'hFFFF_FFFF, 2'b10, 10'd1023, 1'b1, 1'b1,
                 {4{64'h0123456789ABCDEF}}, {4{64'hFEDCBA9876543210}});
        cmd(2'b01, 8'h01, 32'hFFFF_FFFF, 10);
        for (int k = 0; k < 1090; k++) begin
            logic [3:0] kn;
            kn = 4'(k);
            pulse(k < 64 ? kn : 4'hF, k < 64 ? ~kn : 4'hF);
        end
        endt();
        // back-to-back: short write then a runt after one SCK period of cs high
        push_rec(8'h04, 32'h1111_1111, 2'b10, 10'd12, 1'b1, 1'b1, {8'h99, 248'h0}, {8'h33, 248'h0});
        cmd(2'b01, 8'h04, 32'h1111_1111, 10);
        pulse(4'h9, 4'h3);
        pulse(4'h9, 4'h3);
        endt();
        push_rec(8'h55, 32'h0000_0066, 2'b01, 10'd4, 1'b0, 1'b0, '0, '0);
        cmd(2'b10, 8'h55, 32'h6600_0000, 4);
        endt();
        repeat (10) @(negedge clk);
        chk("rec_left", 32'(exp_q.size()), 0);
        chk("nib_left", 32'(nib_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/genx_qspi_slave.md
# genx_qspi_slave

Clock-domain QSPI target front end for the GenX QSPI simulator. Oversamples SCK, chip-selects and both quad data buses with the system clock. Deserializes opcode, address and write data, and serializes read data back onto the bus. Its outputs feed genx_qspi_handler directly (sck_counts, opcode, address, chip_select, wdata_h/l, notify_read/write), and it consumes the handler's rdata_h/l.

## Interface
- SYNC_STAGES, 2: flops in each input synchronizer (≥2)
- DUMMY_CLKS, 4: SCK cycles between end of address and first read nibble (≥1)
- RD_OPCODE_BIT, 7: opcode bit that, when 1, marks a read transaction
- clk  in  1  system clock; must be ≥8× SCK frequency
- resetn  in  1  asynchronous, active-low reset
- sck  in  1  QSPI clock, asynchronous
- cs_n  in  2  chip-selects, active low; bit1 = host, bit0 = bank
- dq_h_in  in  4  quad data in, high chip; carries command and high data
- dq_l_in  in  4  quad data in, low chip; carries low data
- dq_h_out / dq_l_out  out  4 each  read nibbles
- dq_oe  out  1  output enable for both buses
- sck_counts  out  10  SCK rising edges this transaction, saturating at 1023
- opcode  out  8  captured opcode
- address  out  32  captured address
- chip_select  out  2  ~cs_n latched at first SCK rise
- wdata_h / wdata_l  out  256 each  captured write data, MSB-first
- rdata_h / rdata_l  in  256 each  read data from handler
- notify_read  out  1  level: command phase complete
- notify_write  out  1  level: transaction ended

## Operation
- **Synchronizers.** All asynchronous inputs pass through SYNC_STAGES flops. SCK rise and fall are detected from the synchronized SCK and its one-cycle-delayed copy.
- **Transaction start.** A transaction starts when the synchronized cs_n moves from 2'b11 to any other value. On start:
  - sck_counts, opcode, address, wdata_h and wdata_l clear to 0.
  - notify_read and notify_write clear to 0.
  - The state machine enters CMD.
- **States.**
  - IDLE → CMD on start.
  - CMD → DATA_WR or DUMMY after rising edge 10.
  - DUMMY → DATA_RD after DUMMY_CLKS further rising edges.
  - Any state except IDLE → IDLE when cs_n returns to 2'b11.
- **CMD capture.** Each SCK rise shifts dq_h_in in, high nibble first:
  - edges 1–2 form opcode;
  - edges 3–10 form address;
  - chip_select latches on edge 1.
- **notify_read** is set in the cycle after edge 10.
- **DATA_WR** is entered when opcode[RD_OPCODE_BIT] = 0.
  - Rising edges 11–74 shift dq_h_in into wdata_h and dq_l_in into wdata_l, MSB-first.
  - Edges beyond 74 are counted but their data is discarded.
  - Nibbles not received remain 0, left-justified (bits 255 downward hold the received data).
- **DUMMY / DATA_RD** is entered when opcode[RD_OPCODE_BIT] = 1.
  - On the first SCK fall of DATA_RD, rdata_h/l load into the shift registers and dq_oe = 1.
  - dq_*_out present bits [255:252].
  - Each subsequent fall shifts left by 4.
  - After 64 nibbles, dq_*_out = 0 while dq_oe stays at 1.
- **End.** When cs_n returns to 2'b11:
  - dq_oe = 0.
  - If sck_counts ≥ 10, notify_write is set.
  - If sck_counts < 10 (runt), notify_write stays 0 and all captured fields keep their partial values.
- **Output hold.** All captured outputs hold their values until the next transaction start.

## Timing
- **Reset.** Every output is 0, dq_oe = 0, state is IDLE, and synchronizer flops are 0. Reset asserted mid-transaction aborts it with no notify.
- **Edge latency.** A pin edge is acted on SYNC_STAGES+1 clk cycles after it occurs. notify_read rises SYNC_STAGES+2 cycles after the 10th SCK rise.
- **Read data setup.** dq_*_out changes SYNC_STAGES+2 cycles after the SCK fall, which is inside half an SCK period at the required clk:SCK ratio. rdata is sampled at the first DATA_RD fall. DUMMY_CLKS ≥ 1 guarantees the handler's one-cycle rdata register has settled.
- **Simultaneous events.** If cs_n deassertion and an SCK edge are detected in the same cycle, deassertion wins and the edge is ignored.
- **sck_counts** updates 1 cycle after each detected rise and saturates at 1023 with no wrap.
- **Chip-select glitch.** A cs_n change between two non-11 values mid-transaction does not restart the transaction. chip_select keeps its edge-1 value.

## Test plan
- **Reset.** Assert resetn = 0 mid-write → all outputs 0, dq_oe = 0, no notify; the next transaction captures normally.
- **Host write.**
  - Stimulus: cs_n = 2'b01, opcode 0x02, address 0x0000_1234, 8 data nibbles 0xDEADBEEF on dq_h, then deassert.
  - Required: opcode = 0x02, address = 0x1234, chip_select = 2'b10, wdata_h[255:224] = 0xDEADBEEF, rest 0, sck_counts = 18, notify_write = 1.
- **Read.**
  - Stimulus: opcode 0x83, DUMMY_CLKS = 4, rdata_h[255:224] = 0xCAFEF00D.
  - Required: notify_read rises after edge 10; nibbles C,A,F,E,F,0,0,D appear on dq_h_out on the falls after 14 rises; dq_oe drops at deassert.
- **Runt.** 6 SCK rises then deassert → notify_write = 0, notify_read = 0, sck_counts = 6.
- **Overrun.** A 1100-edge write → sck_counts = 1023, wdata holds only edges 11–74.
- **Back-to-back.** Two transactions separated by 1 SCK period of cs_n high → notify flags clear at the second start; the second transaction's fields fully replace the first's.
